// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA link.
// Samples an external sync pair and the 16-bit ADC colour bus in the pixel clock
// domain. It recovers horizontal and vertical timing and checks the line period.
// Once the timing is locked it emits per-pixel coordinates with a valid strobe.
//
// Ports:
//   clk25        pixel clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   hsync_in     raw horizontal sync
//   vsync_in     raw vertical sync
//   adc_pixel_in digitised colour, same format as the DAC-side bus
//   pixel_out    captured pixel (0 when not valid)
//   pixel_x      column 0..H_ACTIVE-1 (0 when not valid)
//   pixel_y      row 0..V_ACTIVE-1 (0 when not valid)
//   pixel_valid  pixel_out/x/y meaningful this cycle
//   frame_start  one-cycle pulse with pixel (0,0)
//   locked       timing lock status
//
// Lock FSM:
//   state      | meaning
//   SEARCH     | counting consecutive lines of period H_TOTAL
//   WAIT_FRAME | enough good lines seen, waiting for the end of vsync
//   LOCKED     | timing trusted, active-window pixels are emitted
module vga_capture #(
    parameter int H_ACTIVE        = 640,
    parameter int H_BACK_PORCH    = 48,
    parameter int H_TOTAL         = 800,
    parameter int V_ACTIVE        = 480,
    parameter int V_BACK_PORCH    = 33,
    parameter int LOCK_LINES      = 4,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [15:0] adc_pixel_in,
    output logic [15:0] pixel_out,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked
);

    localparam logic [10:0] HTOT   = 11'(H_TOTAL);
    localparam logic [9:0]  HBP    = 10'(H_BACK_PORCH);
    localparam logic [9:0]  HEND   = 10'(H_BACK_PORCH + H_ACTIVE);
    localparam logic [9:0]  VBP    = 10'(V_BACK_PORCH);
    localparam logic [9:0]  VEND   = 10'(V_BACK_PORCH + V_ACTIVE);
    localparam logic [9:0]  HLOST  = 10'(H_TOTAL + 16);
    localparam logic [7:0]  LOCKN  = 8'(LOCK_LINES);
    localparam logic [9:0]  CNTMAX = 10'h3FF;

    typedef enum logic [1:0] {
        SEARCH     = 2'd0,
        WAIT_FRAME = 2'd1,
        LOCKED     = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  gc;
    logic        meas;      // a reference h_end has been seen since reset/SEARCH entry

    logic        hs_act, vs_act;    // registered, polarity normalised (1 = pulse)
    logic        hs_prev, vs_prev;
    logic [15:0] pix_r;
    logic [9:0]  hc, ln;

    logic        h_end, v_end, period_ok, win, emit;

    // Input stage; the sync levels are normalised so that 1 means "in the pulse".
    always_ff @(posedge clk25) begin
        if (rst) begin
            hs_act  <= 1'b0;
            vs_act  <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            pix_r   <= '0;
        end else begin
            hs_act  <= (SYNC_ACTIVE_LOW != 0) ? ~hsync_in : hsync_in;
            vs_act  <= (SYNC_ACTIVE_LOW != 0) ? ~vsync_in : vsync_in;
            hs_prev <= hs_act;
            vs_prev <= vs_act;
            pix_r   <= adc_pixel_in;
        end
    end

    assign h_end     = hs_prev & ~hs_act;
    assign v_end     = vs_prev & ~vs_act;
    // hc holds (line length - 1) at the h_end that closes the line.
    assign period_ok = ({1'b0, hc} + 11'd1) == HTOT;
    assign win       = (hc >= HBP) && (hc < HEND) && (ln >= VBP) && (ln < VEND);
    assign emit      = win && (state == LOCKED);

    // Timing counters run regardless of lock; lock only gates the outputs.
    always_ff @(posedge clk25) begin
        if (rst) begin
            hc <= '0;
            ln <= '0;
        end else begin
            if (h_end)
                hc <= '0;
            else if (hc != CNTMAX)
                hc <= hc + 10'd1;

            // v_end wins over a coincident h_end, so that line becomes line 0.
            if (v_end)
                ln <= '0;
            else if (h_end && (ln != CNTMAX))
                ln <= ln + 10'd1;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state       <= SEARCH;
            gc          <= '0;
            meas        <= 1'b0;
            pixel_out   <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (h_end) begin
                        if (!meas) begin
                            meas <= 1'b1;
                        end else if (period_ok) begin
                            gc <= gc + 8'd1;
                            if ((gc + 8'd1) >= LOCKN)
                                state <= WAIT_FRAME;
                        end else begin
                            gc <= '0;
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (h_end && !period_ok) begin
                        state <= SEARCH;
                        gc    <= '0;
                        meas  <= 1'b0;
                    end else if (v_end) begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    // A wrong period or a missing hsync both drop lock.
                    if ((h_end && !period_ok) || (!h_end && (hc >= HLOST))) begin
                        state <= SEARCH;
                        gc    <= '0;
                        meas  <= 1'b0;
                    end
                end
                default: begin
                    state <= SEARCH;
                    gc    <= '0;
                    meas  <= 1'b0;
                end
            endcase

            pixel_valid <= emit;
            pixel_out   <= emit ? pix_r : 16'd0;
            pixel_x     <= emit ? (hc - HBP) : 10'd0;
            pixel_y     <= emit ? (ln - VBP) : 10'd0;
            frame_start <= emit && (hc == HBP) && (ln == VBP);
            locked      <= (state == LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture.
// It uses a scaled-down timing so that many frames fit in a short run:
// 32 clocks/line, 4-clock hsync, back porch 4, 16 active columns,
// 12 lines/frame, 2-line vsync, back porch 3, 6 active rows.
// A driver pushes the expected pixels into a queue, and a monitor pops one each
// time the DUT raises pixel_valid.
module tb_vga_capture;

    localparam int NL    = 12;
    localparam int HS_W  = 4;
    // hc clears on raw column HS_W+1 (one input register plus edge detect),
    // so hc == back porch (4) falls on raw column 9.
    localparam int COL0  = 9;
    localparam int COLN  = 25;
    localparam int BIG   = 1 << 30;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] pix;
        logic        fs;
    } exp_t;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [15:0] adc_pixel_in = '0;
    logic [15:0] pixel_out;
    logic [9:0]  pixel_x, pixel_y;
    logic        pixel_valid, frame_start, locked;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   n_fs = 0;
    bit   mon_en = 1'b0;
    int   bv, bf;

    vga_capture #(
        .H_ACTIVE(16), .H_BACK_PORCH(4), .H_TOTAL(32),
        .V_ACTIVE(6), .V_BACK_PORCH(3), .LOCK_LINES(4), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk25(clk25), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .adc_pixel_in(adc_pixel_in), .pixel_out(pixel_out), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .pixel_valid(pixel_valid), .frame_start(frame_start),
        .locked(locked)
    );

    always #5 clk25 = ~clk25;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk25) begin
        if (mon_en) begin
            if (pixel_valid) begin
                n_valid++;
                if (frame_start) n_fs++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {pixel_x, pixel_y}, 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pixel_x", pixel_x, e.x);
                    check("pixel_y", pixel_y, e.y);
                    check("pixel_out", pixel_out, e.pix);
                    check("frame_start", frame_start, e.fs);
                end
            end else begin
                check("idle_zero", {pixel_out, pixel_x, pixel_y, frame_start}, 64'd0);
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, pixel_valid, 0);
        check({name, "_locked"}, locked, 0);
        check({name, "_fs"}, frame_start, 0);
        check({name, "_pix"}, pixel_out, 0);
        check({name, "_x"}, pixel_x, 0);
        check({name, "_y"}, pixel_y, 0);
    endtask

    task automatic do_reset();
        @(negedge clk25);
        rst = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        adc_pixel_in = '0;
        repeat (3) @(negedge clk25);
        mon_en = 1'b1;
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    // One frame: len clocks/line, vsync edges at column vs_col, and active rows
    // starting at raw line voff. lk means the DUT is expected locked this frame.
    // No pixel at raw position > cut is expected. drop_line suppresses that
    // line's hsync pulse. rst_pos pulses rst at that raw position.
    task automatic drive_frame(input int len, input int vs_col, input int voff, input bit lk,
                               input int cut, input int drop_line, input int rst_pos);
        for (int l = 0; l < NL; l++) begin
            for (int c = 0; c < len; c++) begin
                int   pos;
                exp_t e;
                @(negedge clk25);
                pos = l * len + c;
                // hc reaches 48 on raw column 21 of the dropped line; state leaves
                // LOCKED on the next edge and locked follows one edge later.
                if (l == drop_line && c == 23) check("lost_sync_hold", locked, 1);
                if (l == drop_line && c == 24) check("lost_sync_drop", locked, 0);
                if (pos == rst_pos + 1) check_all_zero("mid_reset");
                hsync_in     = !((c < HS_W) && (l != drop_line));
                vsync_in     = !((pos >= vs_col) && (pos < 2 * len + vs_col));
                adc_pixel_in = {10'(c - HS_W - 1), 6'(l)};
                rst          = (pos == rst_pos);
                if (lk && pos <= cut && l >= voff && l < voff + 6 && c >= COL0 && c < COLN) begin
                    e.x   = 10'(c - COL0);
                    e.y   = 10'(l - voff);
                    e.pix = adc_pixel_in;
                    e.fs  = (c == COL0) && (l == voff);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Nominal: lock during frame 0 (4 good lines), LOCKED at frame 1 vsync end.
        bv = n_valid; bf = n_fs;
        drive_frame(32, 0, 4, 0, BIG, -1, -100);
        check("nom_lock_f0", locked, 0);
        drive_frame(32, 0, 4, 1, BIG, -1, -100);
        check("nom_lock_f1", locked, 1);
        drive_frame(32, 0, 4, 1, BIG, -1, -100);
        check("nom_valid_count", n_valid - bv, 192);
        check("nom_fs_count", n_fs - bf, 2);

        // Lost sync on raw line 6: only rows on lines 4,5 come out, relock next frame.
        bv = n_valid; bf = n_fs;
        drive_frame(32, 0, 4, 1, 6 * 32 - 1, 6, -100);
        check("lost_lock_after", locked, 0);
        drive_frame(32, 0, 4, 1, BIG, -1, -100);
        check("lost_relock", locked, 1);
        check("lost_valid_count", n_valid - bv, 128);
        check("lost_fs_count", n_fs - bf, 2);

        // Bad period (33 clocks) never locks; 32-clock lines lock one frame later.
        do_reset();
        bv = n_valid; bf = n_fs;
        drive_frame(33, 0, 4, 0, BIG, -1, -100);
        drive_frame(33, 0, 4, 0, BIG, -1, -100);
        check("bad_no_lock", locked, 0);
        drive_frame(32, 0, 4, 0, BIG, -1, -100);
        check("bad_wait_frame", locked, 0);
        drive_frame(32, 0, 4, 1, BIG, -1, -100);
        check("bad_relock", locked, 1);
        check("bad_valid_count", n_valid - bv, 96);
        check("bad_fs_count", n_fs - bf, 1);

        // Coincident h_end/v_end: that line is ln 0, first active row is raw line 5.
        do_reset();
        bv = n_valid; bf = n_fs;
        drive_frame(32, HS_W, 5, 0, BIG, -1, -100);
        drive_frame(32, HS_W, 5, 1, BIG, -1, -100);
        check("coin_lock", locked, 1);
        check("coin_valid_count", n_valid - bv, 96);
        check("coin_fs_count", n_fs - bf, 1);

        // Reset at row 2 column 6: the pixel in flight is lost, then a full relock.
        do_reset();
        bv = n_valid; bf = n_fs;
        drive_frame(32, 0, 4, 0, BIG, -1, -100);
        drive_frame(32, 0, 4, 1, BIG, -1, -100);
        drive_frame(32, 0, 4, 1, 6 * 32 + 13, -1, 6 * 32 + 15);
        check("mrst_wait", locked, 0);
        drive_frame(32, 0, 4, 1, BIG, -1, -100);
        check("mrst_relock", locked, 1);
        check("mrst_valid_count", n_valid - bv, 229);
        check("mrst_fs_count", n_fs - bf, 3);

        repeat (4) @(negedge clk25);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
